rf_sb: RTL and testbench
========================

# rf_sb

Parametrised register file with an integrated write-pending scoreboard, for the pipelined datapath. It provides two combinational read ports and one clocked write port, with configurable data width and register count. Each register has a busy bit: decode sets it when it reserves the register as a destination, and writeback clears it. Read ports report the busy bit alongside the data so hazard logic can stall. An optional write-to-read bypass is compiled in by macro.

## Interface
- WIDTH, 16, data width of each register in bits.
- AW, 3, register address width. Register count is NREGS = 2**AW.
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- read1_reg  input  AW  read port 1 address.
- read1_data  output  WIDTH  read port 1 data.
- read1_busy  output  1  busy bit of read1_reg.
- read2_reg  input  AW  read port 2 address.
- read2_data  output  WIDTH  read port 2 data.
- read2_busy  output  1  busy bit of read2_reg.
- write_reg  input  AW  writeback destination.
- write_data  input  WIDTH  writeback data.
- write_en  input  1  writeback strobe. Writes data and clears the busy bit.
- rsv_reg  input  AW  destination register to reserve.
- rsv_en  input  1  reserve strobe. Sets the busy bit.
- flush  input  1  synchronous clear of all busy bits. Does not affect data.
- rsv_err  output  1  sticky flag: a reservation was attempted on an already-busy register.
- busy_cnt  output  AW+1  number of registers currently busy.

## Operation
- State per register: data[WIDTH-1:0] and busy.
- Global state: rsv_err, plus a busy_cnt register maintained incrementally; it is not recomputed as a popcount.
- Reads are combinational from the current state (subject to the bypass described under Configuration).
- Write: when write_en is high, data[write_reg] <= write_data and busy[write_reg] <= 0.
  - Writing a register that is not busy is legal and is not an error.
- Reserve: when rsv_en is high and busy[rsv_reg] is 0, busy[rsv_reg] <= 1.
- Reserve on a busy register:
  - If busy[rsv_reg] is 1 and the same register is not being written this cycle, busy is unchanged and rsv_err <= 1.
  - rsv_err stays set until reset.
- Simultaneous write_en and rsv_en to the same register:
  - Data is written and busy ends at 1, because the new reservation wins.
  - This is not an error.
- Simultaneous write_en and rsv_en to different registers: both take effect independently.
- Flush:
  - All busy bits are cleared.
  - rsv_en is ignored in that cycle and does not raise rsv_err.
  - A write in the same cycle still updates data.
- busy_cnt tracks the busy bits. Net change per cycle is +1, 0, or -1, or it clears to 0 on flush.
  - It never exceeds NREGS, which is why it is AW+1 bits wide.
- Reset (rst low), asynchronous and taking effect immediately, even mid-operation:
  - all data = 0
  - all busy = 0
  - rsv_err = 0
  - busy_cnt = 0
- Output values in reset follow from that state: read data is 0 and read busy is 0.

## Timing
- Read latency: 0 cycles, combinational from the address and state.
- Write latency: data and busy are visible on the read ports in the cycle after the edge. With the bypass enabled, they are visible in the same cycle.
- Reserve latency: busy is visible in the cycle after the edge. Reservations are never bypassed.
- rsv_err and busy_cnt are registered and update 1 cycle after the causing edge.
- Reset deassertion is expected to be synchronised externally. The first active edge after rst goes high performs normal updates.
- There are no handshakes and no stalls inside the block; every strobe is accepted in its cycle.

## Configuration
- Macro: RF_SB_BYPASS_EN.
- Defined: while write_en is high and readN_reg == write_reg:
  - readN_data = write_data.
  - readN_busy = 0.
  - This applies per port and independently of the other port.
- Not defined: read ports show registered state only. A same-cycle read of write_reg returns the old data and the old busy bit.

## Test plan
- Reset: hold rst low with random strobes active.
  - Every read of registers 0..7 returns 0 with busy 0.
  - busy_cnt = 0, rsv_err = 0.
- Basic read/write: write 0xBEEF to r5, then read r5 on both ports the next cycle.
  - Both ports return 0xBEEF with busy 0.
  - Same-cycle read without RF_SB_BYPASS_EN returns 0; with it, returns 0xBEEF.
- Scoreboard: reserve r2 then r3, then write 0x1234 to r2.
  - busy_cnt goes 1, 2, 1.
  - read1_busy(r3) = 1, read2_busy(r2) = 0, read2_data = 0x1234.
- Collisions:
  - Reserve r4, then issue write r4 = 0x00AA and reserve r4 in the same cycle: busy(r4) stays 1, data = 0x00AA, rsv_err = 0.
  - Then reserve r4 again alone: rsv_err = 1, busy_cnt unchanged.
- Flush: reserve r1, r6 and r7, then assert flush with rsv_en on r0 and a write of 0x5555 to r1.
  - All busy bits = 0, busy_cnt = 0.
  - r1 = 0x5555, r0 is not busy.
- Mid-operation reset: with WIDTH=32 and AW=4, fill all 16 registers and reserve all 16 (busy_cnt = 16), then pulse rst low between clock edges.
  - Outputs read 0 immediately.
  - busy_cnt = 0.

Source files
------------

// File: rtl/rf_sb.sv
// rf_sb: register file with two combinational read ports, one write port and a
// per-register write-pending scoreboard. Define RF_SB_BYPASS_EN for write-to-read bypass.
module rf_sb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    read1_reg,
  output logic [WIDTH-1:0] read1_data,
  output logic             read1_busy,
  input  logic [AW-1:0]    read2_reg,
  output logic [WIDTH-1:0] read2_data,
  output logic             read2_busy,
  input  logic [AW-1:0]    write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  input  logic [AW-1:0]    rsv_reg,
  input  logic             rsv_en,
  input  logic             flush,
  output logic             rsv_err,
  output logic [AW:0]      busy_cnt
);
  localparam int unsigned NREGS = 2**AW;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_data [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_rsv_err;
  logic [AW:0]      r_busy_cnt;

  logic             w_rsv_take;
  logic             w_rsv_bad;
  logic             w_inc;
  logic             w_dec;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_byp1;
  logic             w_byp2;

  always_comb begin
    w_rsv_take = 1'b0;
    w_rsv_bad  = 1'b0;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      // A reservation of the register being written this cycle wins over the clear.
      w_rsv_take = rsv_en && (!r_busy[rsv_reg] || (write_en && (write_reg == rsv_reg)));
      w_rsv_bad  = rsv_en && !w_rsv_take;
      if (write_en)   w_busy_nxt[write_reg] = 1'b0;
      if (w_rsv_take) w_busy_nxt[rsv_reg]   = 1'b1;
      w_inc = w_rsv_take && !r_busy[rsv_reg];
      w_dec = write_en && r_busy[write_reg] && !(w_rsv_take && (rsv_reg == write_reg));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= '{default: '0};
      r_busy     <= '0;
      r_rsv_err  <= 1'b0;
      r_busy_cnt <= '0;
    end else begin
      if (write_en)  r_data[write_reg] <= write_data;
      r_busy <= w_busy_nxt;
      if (w_rsv_bad) r_rsv_err <= 1'b1;
      if (flush)                 r_busy_cnt <= '0;
      else if (w_inc && !w_dec)  r_busy_cnt <= r_busy_cnt + CNT_ONE;
      else if (w_dec && !w_inc)  r_busy_cnt <= r_busy_cnt - CNT_ONE;
    end
  end

`ifdef RF_SB_BYPASS_EN
  // Bypass is gated by reset so outputs read zero while reset is held.
  assign w_byp1 = rst && write_en && (read1_reg == write_reg);
  assign w_byp2 = rst && write_en && (read2_reg == write_reg);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    read1_data = w_byp1 ? write_data : r_data[read1_reg];
    read1_busy = w_byp1 ? 1'b0 : r_busy[read1_reg];
    read2_data = w_byp2 ? write_data : r_data[read2_reg];
    read2_busy = w_byp2 ? 1'b0 : r_busy[read2_reg];
  end

  assign rsv_err  = r_rsv_err;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_rf_sb.sv
// Self-checking bench for rf_sb: directed scenarios plus randomized traffic
// checked against an array-based reference model; second instance at WIDTH=32, AW=4.
module tb_rf_sb;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned NREGS = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    read1_reg, read2_reg, write_reg, rsv_reg;
  logic [WIDTH-1:0] read1_data, read2_data, write_data;
  logic             read1_busy, read2_busy, write_en, rsv_en, flush, rsv_err;
  logic [AW:0]      busy_cnt;

  logic        b_rst;
  logic [3:0]  b_read1_reg, b_read2_reg, b_write_reg, b_rsv_reg;
  logic [31:0] b_read1_data, b_read2_data, b_write_data;
  logic        b_read1_busy, b_read2_busy, b_write_en, b_rsv_en, b_flush, b_rsv_err;
  logic [4:0]  b_busy_cnt;

  always #5 clk = ~clk;

  rf_sb #(.WIDTH(WIDTH), .AW(AW)) u_dut (
    .clk(clk), .rst(rst),
    .read1_reg(read1_reg), .read1_data(read1_data), .read1_busy(read1_busy),
    .read2_reg(read2_reg), .read2_data(read2_data), .read2_busy(read2_busy),
    .write_reg(write_reg), .write_data(write_data), .write_en(write_en),
    .rsv_reg(rsv_reg), .rsv_en(rsv_en), .flush(flush),
    .rsv_err(rsv_err), .busy_cnt(busy_cnt)
  );

  rf_sb #(.WIDTH(32), .AW(4)) u_big (
    .clk(clk), .rst(b_rst),
    .read1_reg(b_read1_reg), .read1_data(b_read1_data), .read1_busy(b_read1_busy),
    .read2_reg(b_read2_reg), .read2_data(b_read2_data), .read2_busy(b_read2_busy),
    .write_reg(b_write_reg), .write_data(b_write_data), .write_en(b_write_en),
    .rsv_reg(b_rsv_reg), .rsv_en(b_rsv_en), .flush(b_flush),
    .rsv_err(b_rsv_err), .busy_cnt(b_busy_cnt)
  );

  logic [WIDTH-1:0] m_data [NREGS];
  logic [NREGS-1:0] m_busy;
  logic             m_err;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_data[i] = '0;
    m_busy = '0;
    m_err  = 1'b0;
  endtask

  // Applies the architectural rules for one rising edge to the model.
  task automatic model_edge();
    if (write_en) m_data[write_reg] = write_data;
    if (flush) begin
      m_busy = '0;
    end else begin
      if (write_en) m_busy[write_reg] = 1'b0;
      if (rsv_en) begin
        if (m_busy[rsv_reg]) m_err = 1'b1;
        else                 m_busy[rsv_reg] = 1'b1;
      end
    end
  endtask

  task automatic check_reads(input string tag);
    logic [WIDTH-1:0] e1, e2;
    logic             b1, b2;
    e1 = m_data[read1_reg];
    b1 = m_busy[read1_reg];
    e2 = m_data[read2_reg];
    b2 = m_busy[read2_reg];
`ifdef RF_SB_BYPASS_EN
    if (rst && write_en && read1_reg == write_reg) begin e1 = write_data; b1 = 1'b0; end
    if (rst && write_en && read2_reg == write_reg) begin e2 = write_data; b2 = 1'b0; end
`endif
    chk({tag, ".rd1_data"}, 64'(read1_data), 64'(e1));
    chk({tag, ".rd1_busy"}, 64'(read1_busy), 64'(b1));
    chk({tag, ".rd2_data"}, 64'(read2_data), 64'(e2));
    chk({tag, ".rd2_busy"}, 64'(read2_busy), 64'(b2));
    chk({tag, ".busy_cnt"}, 64'(busy_cnt), 64'($countones(m_busy)));
    chk({tag, ".rsv_err"},  64'(rsv_err), 64'(m_err));
  endtask

  // Inputs are applied in the low phase; reads are checked before the edge.
  task automatic tick(input string tag);
    #1 check_reads(tag);
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    write_en = 1'b0;
    rsv_en   = 1'b0;
    flush    = 1'b0;
  endtask

  logic [31:0] big_vals [16];
  int          cnt_before;

  initial begin
    rst = 1'b0; b_rst = 1'b0;
    read1_reg = '0; read2_reg = '0; write_reg = '0; rsv_reg = '0; write_data = '0;
    idle();
    b_read1_reg = '0; b_read2_reg = '0; b_write_reg = '0; b_rsv_reg = '0;
    b_write_data = '0; b_write_en = 1'b0; b_rsv_en = 1'b0; b_flush = 1'b0;
    model_reset();

    // Reset held with random strobes active
    for (int i = 0; i < NREGS; i++) begin
      read1_reg  = AW'(i);
      read2_reg  = AW'(NREGS - 1 - i);
      write_reg  = AW'($urandom);
      write_data = WIDTH'($urandom);
      write_en   = 1'b1;
      rsv_reg    = AW'($urandom);
      rsv_en     = 1'b1;
      flush      = 1'($urandom);
      tick("reset");
    end
    rst = 1'b1;
    idle();

    // Basic write then read
    write_reg = 3'd5; write_data = 16'hBEEF; write_en = 1'b1;
    read1_reg = 3'd5; read2_reg = 3'd5;
    tick("wr_same");
    idle();
    tick("wr_next");
    chk("basic.rd1", 64'(read1_data), 64'h BEEF);
    chk("basic.rd2", 64'(read2_data), 64'h BEEF);

    // Scoreboard
    rsv_reg = 3'd2; rsv_en = 1'b1;
    tick("sb_rsv2");
    chk("sb.cnt1", 64'(busy_cnt), 64'd1);
    rsv_reg = 3'd3;
    tick("sb_rsv3");
    chk("sb.cnt2", 64'(busy_cnt), 64'd2);
    idle();
    write_reg = 3'd2; write_data = 16'h1234; write_en = 1'b1;
    read1_reg = 3'd3; read2_reg = 3'd2;
    tick("sb_wr2");
    idle();
    tick("sb_after");
    chk("sb.cnt3", 64'(busy_cnt), 64'd1);
    chk("sb.busy_r3", 64'(read1_busy), 64'd1);
    chk("sb.busy_r2", 64'(read2_busy), 64'd0);
    chk("sb.data_r2", 64'(read2_data), 64'h1234);

    // Collisions
    rsv_reg = 3'd4; rsv_en = 1'b1;
    tick("col_rsv4");
    write_reg = 3'd4; write_data = 16'h00AA; write_en = 1'b1;
    tick("col_wr_rsv4");
    idle();
    read1_reg = 3'd4;
    tick("col_after");
    chk("col.busy_r4", 64'(read1_busy), 64'd1);
    chk("col.data_r4", 64'(read1_data), 64'h00AA);
    chk("col.err0", 64'(rsv_err), 64'd0);
    cnt_before = int'(busy_cnt);
    rsv_reg = 3'd4; rsv_en = 1'b1;
    tick("col_rerr");
    idle();
    tick("col_err");
    chk("col.err1", 64'(rsv_err), 64'd1);
    chk("col.cnt_same", 64'(busy_cnt), 64'(cnt_before));

    // Flush
    rsv_en = 1'b1;
    rsv_reg = 3'd1; tick("fl_rsv1");
    rsv_reg = 3'd6; tick("fl_rsv6");
    rsv_reg = 3'd7; tick("fl_rsv7");
    flush = 1'b1; rsv_reg = 3'd0;
    write_reg = 3'd1; write_data = 16'h5555; write_en = 1'b1;
    tick("fl_flush");
    idle();
    read1_reg = 3'd1; read2_reg = 3'd0;
    tick("fl_after");
    chk("fl.cnt", 64'(busy_cnt), 64'd0);
    chk("fl.data_r1", 64'(read1_data), 64'h5555);
    chk("fl.busy_r1", 64'(read1_busy), 64'd0);
    chk("fl.busy_r0", 64'(read2_busy), 64'd0);

    // Randomized traffic from a fresh reset
    rst = 1'b0;
    model_reset();
    tick("rand_rst");
    rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      read1_reg  = AW'($urandom);
      read2_reg  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom);
      write_reg  = AW'($urandom);
      write_data = WIDTH'($urandom);
      write_en   = 1'($urandom);
      rsv_reg    = ($urandom_range(0, 7) == 0) ? write_reg : AW'($urandom);
      rsv_en     = 1'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      tick("rand");
    end
    idle();

    // Wide instance: fill and reserve everything, then reset between edges
    b_rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      big_vals[i]  = $urandom;
      b_write_reg  = 4'(i);
      b_write_data = big_vals[i];
      b_write_en   = 1'b1;
      b_rsv_reg    = 4'(i);
      b_rsv_en     = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    b_write_en = 1'b0; b_rsv_en = 1'b0;
    b_read1_reg = 4'd9; b_read2_reg = 4'd15;
    #1;
    chk("big.cnt16", 64'(b_busy_cnt), 64'd16);
    chk("big.data9", 64'(b_read1_data), 64'(big_vals[9]));
    chk("big.busy15", 64'(b_read2_busy), 64'd1);
    @(posedge clk);
    #2;
    b_write_en = 1'b1; b_rsv_en = 1'b1; b_write_reg = 4'd9; b_write_data = 32'hDEAD_BEEF;
    b_rst = 1'b0;
    #1;
    chk("big.rst_data", 64'(b_read1_data), 64'd0);
    chk("big.rst_busy", 64'(b_read2_busy), 64'd0);
    chk("big.rst_cnt", 64'(b_busy_cnt), 64'd0);
    for (int i = 0; i < 16; i++) begin
      b_read1_reg = 4'(i);
      #1;
      chk("big.rst_rd", 64'(b_read1_data), 64'd0);
    end
    @(negedge clk);
    b_write_en = 1'b0; b_rsv_en = 1'b0;
    b_rst = 1'b1;
    #1;
    chk("big.post_cnt", 64'(b_busy_cnt), 64'd0);
    chk("big.post_err", 64'(b_rsv_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
